sdram_port_scheduler: RTL and testbench

Four-port burst scheduler for the dual-clock SDRAM frame buffer. It decides which FIFO port is serviced next: WR1/WR2 carry camera pixels and RD1/RD2 feed the VGA controller. For the granted port it issues one burst command (port, direction, address, length) to the SDRAM command engine. It also owns the per-port address counters, including wrap at the port's maximum address and reload on a port load strobe.

---
 rtl/sdram_port_scheduler.sv | 162 ++++++++++++++++
 tb/tb_sdram_port_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_scheduler.sv
// Four-port round-robin burst scheduler for the SDRAM frame buffer, with per-port wrapping address counters.
// Optional macro READ_URGENT_EN: nearly-empty read FIFOs preempt the round-robin order.
module sdram_port_addr #(
   parameter int ADDR_W = 22,
   parameter int LEN_W  = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] max,
   input  logic [LEN_W-1:0]  len,
   input  logic              load,
   input  logic              active,
   input  logic              done,
   output logic [ADDR_W-1:0] addr
);
   logic              pend;
   logic [ADDR_W:0]   limit;
   logic              wrap;
   logic [ADDR_W-1:0] next_addr;

   // limit goes negative when max < len, which must wrap rather than underflow
   assign limit     = {1'b0, max} - {{(ADDR_W+1-LEN_W){1'b0}}, len};
   assign wrap      = limit[ADDR_W] || ({1'b0, addr} >= limit);
   assign next_addr = addr + ADDR_W'(len);

   always_ff @(posedge clk) begin
      if (reset) begin
         addr <= base;
         pend <= 1'b0;
      end else if (done) begin
         addr <= (pend || load || wrap) ? base : next_addr;
         pend <= 1'b0;
      end else if (load) begin
         // a reload during an outstanding burst is deferred to its completion
         if (active) pend <= 1'b1;
         else        addr <= base;
      end
   end
endmodule

module sdram_port_scheduler #(
   parameter int ADDR_W = 22,
   parameter int LEN_W  = 9
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [3:0][ADDR_W-1:0] port_base,
   input  logic [3:0][ADDR_W-1:0] port_max,
   input  logic [3:0][LEN_W-1:0]  port_len,
   input  logic [3:0]             port_load,
   input  logic [3:0][LEN_W-1:0]  port_usedw,
   output logic                   cmd_valid,
   input  logic                   cmd_ready,
   output logic [1:0]             cmd_port,
   output logic                   cmd_write,
   output logic [ADDR_W-1:0]      cmd_addr,
   output logic [LEN_W-1:0]       cmd_len,
   input  logic                   cmd_done,
   output logic                   busy
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_BUSY  = 2'd2;

   logic [1:0]             state;
   logic [1:0]             last;
   logic [3:0][ADDR_W-1:0] addr;
   logic [3:0]             elig;
   logic [3:0]             cand;
   logic [3:0]             active;
   logic [3:0]             done_vec;
   logic                   grant_vld;
   logic [1:0]             grant;
   logic [1:0]             idx;
`ifdef READ_URGENT_EN
   logic [3:0]             urgent;
`endif

   always_comb begin
      elig = '0;
      for (int i = 0; i < 4; i++) begin
         if (i < 2) elig[i] = (port_len[i] != '0) && (port_usedw[i] >= port_len[i]);
         else       elig[i] = (port_len[i] != '0) && (port_usedw[i] <  port_len[i]);
         elig[i] = elig[i] && !port_load[i];
      end
      cand = elig;
`ifdef READ_URGENT_EN
      urgent = '0;
      for (int i = 2; i < 4; i++)
         urgent[i] = elig[i] && (port_usedw[i] < (port_len[i] >> 1));
      if (|urgent) cand = urgent;
`endif
      // walk from farthest to nearest so the nearest candidate after last wins
      grant_vld = 1'b0;
      grant     = '0;
      idx       = '0;
      for (int k = 4; k >= 1; k--) begin
         idx = last + 2'(k);
         if (cand[idx]) begin
            grant_vld = 1'b1;
            grant     = idx;
         end
      end
   end

   always_comb begin
      active   = '0;
      done_vec = '0;
      active[cmd_port]   = (state != S_IDLE);
      done_vec[cmd_port] = (state == S_BUSY) && cmd_done;
   end

   for (genvar g = 0; g < 4; g++) begin : g_port
      sdram_port_addr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr (
         .clk    (clk),
         .reset  (reset),
         .base   (port_base[g]),
         .max    (port_max[g]),
         .len    (port_len[g]),
         .load   (port_load[g]),
         .active (active[g]),
         .done   (done_vec[g]),
         .addr   (addr[g])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         last      <= 2'd3;
         cmd_valid <= 1'b0;
         cmd_port  <= '0;
         cmd_write <= 1'b0;
         cmd_addr  <= '0;
         cmd_len   <= '0;
         busy      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (grant_vld) begin
               state     <= S_ISSUE;
               last      <= grant;
               cmd_valid <= 1'b1;
               cmd_port  <= grant;
               cmd_write <= ~grant[1];
               cmd_addr  <= addr[grant];
               cmd_len   <= port_len[grant];
               busy      <= 1'b1;
            end
            S_ISSUE: if (cmd_ready) begin
               state     <= S_BUSY;
               cmd_valid <= 1'b0;
            end
            S_BUSY: if (cmd_done) begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sdram_port_scheduler.sv
// Directed self-checking bench for sdram_port_scheduler; expected values are hand-computed.
module tb_sdram_port_scheduler;
   localparam int ADDR_W = 22;
   localparam int LEN_W  = 9;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [3:0][ADDR_W-1:0] port_base, port_max;
   logic [3:0][LEN_W-1:0]  port_len, port_usedw;
   logic [3:0]             port_load;
   logic                   cmd_valid, cmd_ready, cmd_write, cmd_done, busy;
   logic [1:0]             cmd_port;
   logic [ADDR_W-1:0]      cmd_addr;
   logic [LEN_W-1:0]       cmd_len;

   int n_cmp = 0;
   int n_bad = 0;

   sdram_port_scheduler #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .reset(reset),
      .port_base(port_base), .port_max(port_max), .port_len(port_len),
      .port_load(port_load), .port_usedw(port_usedw),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_port(cmd_port),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .cmd_done(cmd_done), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Waits (bounded) for a command, then accepts it and completes it one cycle later.
   task automatic do_burst(output bit ok, output logic [1:0] p, output logic [ADDR_W-1:0] a);
      for (int i = 0; i < 20 && !cmd_valid; i++) tick();
      ok = cmd_valid;
      p  = cmd_port;
      a  = cmd_addr;
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      cmd_done  = 1'b1;
      tick();
      cmd_done  = 1'b0;
   endtask

   task automatic idle_ports();
      port_len   = '0;
      port_usedw = '0;
      port_load  = '0;
      port_base  = '0;
      port_max   = '0;
   endtask

   task automatic test_reset();
      idle_ports();
      cmd_ready = 1'b0;
      cmd_done  = 1'b0;
      reset = 1'b1;
      tick(); tick();
      n_cmp++;
      if ({cmd_valid, cmd_port, cmd_write, cmd_addr, cmd_len, busy} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got v=%b p=%0d w=%b a=%h l=%0d busy=%b, want all zero",
                  cmd_valid, cmd_port, cmd_write, cmd_addr, cmd_len, busy);
      end
      reset = 1'b0;
   endtask

   task automatic test_single_write();
      bit ok; logic [1:0] p; logic [ADDR_W-1:0] a;
      port_max[0] = 22'd307200; port_len[0] = 9'd128; port_usedw[0] = 9'd128;
      tick();
      n_cmp++;
      if ({cmd_valid, cmd_port, cmd_write, cmd_addr, cmd_len, busy} !==
          {1'b1, 2'd0, 1'b1, 22'd0, 9'd128, 1'b1}) begin
         n_bad++;
         $display("FAIL single_grant: got v=%b p=%0d w=%b a=%0d l=%0d busy=%b, want v=1 p=0 w=1 a=0 l=128 busy=1",
                  cmd_valid, cmd_port, cmd_write, cmd_addr, cmd_len, busy);
      end
      do_burst(ok, p, a);
      n_cmp++;
      if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL single_idle: got v=%b busy=%b, want 0 0", cmd_valid, busy);
      end
      do_burst(ok, p, a);
      port_len[0] = '0;
      n_cmp++;
      if (!ok || p !== 2'd0 || a !== 22'd128) begin
         n_bad++;
         $display("FAIL single_next_addr: got ok=%b p=%0d a=%0d, want ok=1 p=0 a=128", ok, p, a);
      end
   endtask

   task automatic test_round_robin();
      bit ok; logic [1:0] p; logic [ADDR_W-1:0] a;
      logic [1:0] exp_p [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      idle_ports();
      port_base = {22'h3000, 22'h2000, 22'h1000, 22'h0000};
      port_max  = {4{22'h3FFFFF}};
      port_len  = {4{9'd4}};
      port_usedw = {9'd0, 9'd0, 9'd4, 9'd4};
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         do_burst(ok, p, a);
         n_cmp++;
         if (!ok || p !== exp_p[i]) begin
            n_bad++;
            $display("FAIL rr_order[%0d]: got ok=%b port=%0d, want port=%0d", i, ok, p, exp_p[i]);
         end
      end
      n_cmp++;
      if (a !== 22'd4) begin
         n_bad++;
         $display("FAIL rr_addr_after_lap: got %h, want 000004", a);
      end
   endtask

   task automatic test_wrap();
      bit ok; logic [1:0] p; logic [ADDR_W-1:0] a;
      logic [ADDR_W-1:0] exp_a [3] = '{22'h100000, 22'h100080, 22'h100000};
      idle_ports();
      port_base[2] = 22'h100000; port_max[2] = 22'h100100; port_len[2] = 9'd128;
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         do_burst(ok, p, a);
         n_cmp++;
         if (!ok || p !== 2'd2 || a !== exp_a[i]) begin
            n_bad++;
            $display("FAIL wrap[%0d]: got ok=%b p=%0d a=%h, want p=2 a=%h", i, ok, p, a, exp_a[i]);
         end
      end
   endtask

   task automatic test_load_mid_burst();
      bit ok; logic [1:0] p; logic [ADDR_W-1:0] a;
      idle_ports();
      port_max[0] = 22'h3FFFFF; port_len[0] = 9'd128; port_usedw[0] = 9'd128;
      port_base[1] = 22'h1000;
      apply_reset();
      do_burst(ok, p, a);
      do_burst(ok, p, a);
      for (int i = 0; i < 20 && !cmd_valid; i++) tick();
      n_cmp++;
      if (cmd_valid !== 1'b1 || cmd_addr !== 22'd256) begin
         n_bad++;
         $display("FAIL load_pre_addr: got v=%b a=%0d, want v=1 a=256", cmd_valid, cmd_addr);
      end
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      port_base[0] = 22'h200;
      port_load[0] = 1'b1;
      tick();
      port_load[0] = 1'b0;
      n_cmp++;
      if (cmd_addr !== 22'd256 || cmd_port !== 2'd0 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL load_undisturbed: got a=%0d p=%0d busy=%b, want a=256 p=0 busy=1",
                  cmd_addr, cmd_port, busy);
      end
      cmd_done = 1'b1;
      tick();
      cmd_done = 1'b0;
      do_burst(ok, p, a);
      port_len[0] = '0;
      n_cmp++;
      if (!ok || p !== 2'd0 || a !== 22'h200) begin
         n_bad++;
         $display("FAIL load_reload_addr: got ok=%b p=%0d a=%h, want p=0 a=000200", ok, p, a);
      end
      // idle-time reload of an ungranted port takes effect immediately
      port_base[1] = 22'h3000;
      port_load[1] = 1'b1;
      tick();
      port_load[1] = 1'b0;
      port_max[1] = 22'h3FFFFF; port_len[1] = 9'd4; port_usedw[1] = 9'd8;
      do_burst(ok, p, a);
      port_len[1] = '0;
      n_cmp++;
      if (!ok || p !== 2'd1 || a !== 22'h3000) begin
         n_bad++;
         $display("FAIL load_idle_addr: got ok=%b p=%0d a=%h, want p=1 a=003000", ok, p, a);
      end
   endtask

   task automatic test_backpressure();
      idle_ports();
      port_base[3] = 22'h2000; port_max[3] = 22'h3FFFFF; port_len[3] = 9'd16;
      apply_reset();
      for (int i = 0; i < 20 && !cmd_valid; i++) tick();
      for (int i = 0; i < 10; i++) begin
         cmd_done = (i == 3);   // stray done while waiting for ready must be ignored
         tick();
         n_cmp++;
         if ({cmd_valid, cmd_port, cmd_write, cmd_addr, cmd_len, busy} !==
             {1'b1, 2'd3, 1'b0, 22'h2000, 9'd16, 1'b1}) begin
            n_bad++;
            $display("FAIL backpressure[%0d]: got v=%b p=%0d w=%b a=%h l=%0d busy=%b, want v=1 p=3 w=0 a=002000 l=16 busy=1",
                     i, cmd_valid, cmd_port, cmd_write, cmd_addr, cmd_len, busy);
         end
      end
      cmd_done = 1'b0;
   endtask

   task automatic test_reset_mid_burst();
      bit ok; logic [1:0] p; logic [ADDR_W-1:0] a;
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      reset = 1'b1;
      cmd_done = 1'b1;
      tick();
      reset = 1'b0;
      n_cmp++;
      if ({cmd_valid, busy, cmd_addr} !== '0) begin
         n_bad++;
         $display("FAIL reset_mid: got v=%b busy=%b a=%h, want 0 0 0", cmd_valid, busy, cmd_addr);
      end
      tick();
      cmd_done = 1'b0;
      n_cmp++;
      if (cmd_valid !== 1'b1 || busy !== 1'b1 || cmd_addr !== 22'h2000) begin
         n_bad++;
         $display("FAIL reset_mid_regrant: got v=%b busy=%b a=%h, want 1 1 002000", cmd_valid, busy, cmd_addr);
      end
      do_burst(ok, p, a);
   endtask

   task automatic test_urgent();
      bit ok; logic [1:0] p; logic [ADDR_W-1:0] a;
      logic [1:0] exp_p;
`ifdef READ_URGENT_EN
      exp_p = 2'd3;
`else
      exp_p = 2'd1;
`endif
      idle_ports();
      port_max = {4{22'h3FFFFF}};
      port_len[0] = 9'd4; port_usedw[0] = 9'd4;
      apply_reset();
      do_burst(ok, p, a);   // leaves last = 0
      port_len[0] = '0;
      port_len[1] = 9'd4;   port_usedw[1] = 9'd4;
      port_len[3] = 9'd128; port_usedw[3] = 9'd10;
      do_burst(ok, p, a);
      n_cmp++;
      if (!ok || p !== exp_p) begin
         n_bad++;
         $display("FAIL urgent_first: got ok=%b port=%0d, want port=%0d", ok, p, exp_p);
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_round_robin();
      test_wrap();
      test_load_mid_burst();
      test_backpressure();
      test_reset_mid_burst();
      test_urgent();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
